// File: rtl/alu_operand_issue.sv
// Operand fetch / issue stage ahead of the ALU: register file, pending-write scoreboard,
// writeback bypass and a 1-entry output register. R-type fields: rd=[11:7], rs1=[19:15], rs2=[24:20].
module alu_operand_issue #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic                     wb_valid,
   input  logic [$clog2(NREGS)-1:0] wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [XLEN-1:0]          out_rs1_val,
   output logic [XLEN-1:0]          out_rs2_val,
   output logic [$clog2(NREGS)-1:0] out_rd
);
   localparam int IW = $clog2(NREGS);

   logic [IW-1:0]    rs1, rs2, rd;
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] pending_q, pending_d, clr, busy;
   logic             hazard, accept;
   logic [XLEN-1:0]  rs1_val, rs2_val;

   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_instr_q, out_instr_d;
   logic [XLEN-1:0]  out_rs1_q, out_rs1_d;
   logic [XLEN-1:0]  out_rs2_q, out_rs2_d;
   logic [IW-1:0]    out_rd_q, out_rd_d;

   assign rd  = in_instr[7 +: IW];
   assign rs1 = in_instr[15 +: IW];
   assign rs2 = in_instr[20 +: IW];

   // A writeback landing this edge releases its register, so it never stalls issue.
   always_comb begin
      clr = '0;
      if (wb_valid && wb_rd != '0) clr[wb_rd] = 1'b1;
   end

   assign busy     = pending_q & ~clr;
   assign hazard   = busy[rs1] | busy[rs2] | busy[rd];
   assign in_ready = (!out_valid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != '0) rs1_val = clr[rs1] ? wb_data : regs_q[rs1];
      if (rs2 != '0) rs2_val = clr[rs2] ? wb_data : regs_q[rs2];
   end

   // Setting on accept is applied after the clear so a same-edge set wins.
   always_comb begin
      pending_d = pending_q & ~clr;
      if (accept && rd != '0) pending_d[rd] = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_rs1_d   = out_rs1_q;
      out_rs2_d   = out_rs2_q;
      out_rd_d    = out_rd_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_instr_d = in_instr;
         out_rs1_d   = rs1_val;
         out_rs2_d   = rs2_val;
         out_rd_d    = rd;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wb_valid && wb_rd != '0) begin
         regs_q[wb_rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_rs1_q   <= '0;
         out_rs2_q   <= '0;
         out_rd_q    <= '0;
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_rs1_q   <= out_rs1_d;
         out_rs2_q   <= out_rs2_d;
         out_rd_q    <= out_rd_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_rs1_val = out_rs1_q;
   assign out_rs2_val = out_rs2_q;
   assign out_rd      = out_rd_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed scenarios plus randomized traffic checked
// cycle by cycle against an array/scoreboard reference model.
module tb_alu_operand_issue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_rs1_val;
   logic [31:0] out_rs2_val;
   logic [4:0]  out_rd;

   int total = 0;
   int bad   = 0;

   alu_operand_issue #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          m_ov;
   logic [31:0] m_instr, m_v1, m_v2;
   logic [4:0]  m_rd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2, input bit sub);
      logic [6:0] f7;
      f7 = sub ? 7'h20 : 7'h00;
      return {f7, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
   endfunction

   function automatic int f_rd(input logic [31:0] i);  return int'(i[11:7]);  endfunction
   function automatic int f_rs1(input logic [31:0] i); return int'(i[19:15]); endfunction
   function automatic int f_rs2(input logic [31:0] i); return int'(i[24:20]); endfunction

   function automatic bit m_clr(input int i);
      return wb_valid && int'(wb_rd) == i && i != 0;
   endfunction

   function automatic bit m_busy(input int i);
      return i != 0 && m_pend[i] && !m_clr(i);
   endfunction

   function automatic logic [31:0] m_read(input int i);
      if (i == 0) return 32'h0;
      if (m_clr(i)) return wb_data;
      return m_regs[i];
   endfunction

   function automatic bit m_ready();
      bit haz;
      haz = m_busy(f_rs1(in_instr)) || m_busy(f_rs2(in_instr)) || m_busy(f_rd(in_instr));
      return (!m_ov || out_ready) && !haz;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'h0;
         m_pend[i] = 1'b0;
      end
      m_ov = 1'b0; m_instr = 32'h0; m_v1 = 32'h0; m_v2 = 32'h0; m_rd = 5'h0;
   endfunction

   // Called just after a negedge with inputs already driven; returns just after the next negedge.
   task automatic cycle(input string tag);
      bit          acc;
      logic [31:0] v1, v2;
      #1;
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready()));
      acc = in_valid && m_ready();
      v1  = m_read(f_rs1(in_instr));
      v2  = m_read(f_rs2(in_instr));
      @(posedge clk);
      if (wb_valid && wb_rd != 5'd0) begin
         m_regs[wb_rd] = wb_data;
         m_pend[wb_rd] = 1'b0;
      end
      if (acc) begin
         if (f_rd(in_instr) != 0) m_pend[f_rd(in_instr)] = 1'b1;
         m_ov = 1'b1; m_instr = in_instr; m_v1 = v1; m_v2 = v2; m_rd = in_instr[11:7];
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      @(negedge clk);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
         chk({tag, ".out_instr"}, 64'(out_instr), 64'(m_instr));
         chk({tag, ".out_rs1"}, 64'(out_rs1_val), 64'(m_v1));
         chk({tag, ".out_rs2"}, 64'(out_rs2_val), 64'(m_v2));
         chk({tag, ".out_rd"}, 64'(out_rd), 64'(m_rd));
      end
   endtask

   task automatic drive(input bit iv, input logic [31:0] ins, input bit wv,
                        input int wr, input logic [31:0] wd, input bit ordy);
      in_valid = iv; in_instr = ins; wb_valid = wv; wb_rd = wr[4:0]; wb_data = wd; out_ready = ordy;
   endtask

   initial begin
      m_reset();
      rst_n = 1'b0;
      drive(0, 32'h0, 0, 0, 32'h0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.payload", {out_rs1_val, out_rs2_val}, 64'd0);
      chk("rst.instr_rd", {27'd0, out_rd, out_instr}, 64'd0);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      // every register reads zero after reset
      for (int i = 0; i < 32; i++) begin
         drive(1, mk(0, i, 31 - i, 0), 0, 0, 32'h0, 1);
         cycle("rst_read");
         chk("rst_read.vals", {out_rs1_val, out_rs2_val}, 64'd0);
      end

      // basic issue
      drive(0, 32'h0, 1, 5, 32'h10, 1); cycle("t2_wb5");
      drive(0, 32'h0, 1, 6, 32'h3, 1);  cycle("t2_wb6");
      drive(1, mk(7, 5, 6, 0), 0, 0, 32'h0, 1); cycle("t2_add");
      chk("t2.rs1", 64'(out_rs1_val), 64'h10);
      chk("t2.rs2", 64'(out_rs2_val), 64'h3);
      chk("t2.rd", 64'(out_rd), 64'd7);

      // RAW stall, then release via same-cycle writeback bypass
      drive(1, mk(8, 7, 0, 1), 0, 0, 32'h0, 1); #1;
      chk("t3.stall", 64'(in_ready), 64'd0);
      cycle("t3_stall");
      drive(1, mk(8, 7, 0, 1), 1, 7, 32'h13, 1); #1;
      chk("t3.bypass_rdy", 64'(in_ready), 64'd1);
      cycle("t3_bypass");
      chk("t3.rs1", 64'(out_rs1_val), 64'h13);

      // backpressure holds payload
      for (int k = 0; k < 3; k++) begin
         drive(1, mk(9, 5, 6, 0), 0, 0, 32'h0, 0); cycle("t4_hold");
         chk("t4.held_rs1", 64'(out_rs1_val), 64'h13);
      end
      drive(0, 32'h0, 1, 8, 32'h55, 1); cycle("t4_drain");
      chk("t4.drained", 64'(out_valid), 64'd0);

      // x0 behaviour
      drive(0, 32'h0, 1, 0, 32'hDEADBEEF, 1); cycle("t5_wb0");
      drive(1, mk(0, 0, 0, 0), 0, 0, 32'h0, 1); cycle("t5_iss0");
      chk("t5.rs1", 64'(out_rs1_val), 64'd0);
      drive(1, mk(0, 0, 5, 0), 0, 0, 32'h0, 1); cycle("t5_iss0b");

      // async reset mid-operation
      drive(1, mk(7, 5, 6, 0), 0, 0, 32'h0, 1); cycle("t6_iss");
      drive(0, 32'h0, 0, 0, 32'h0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6.async_clr", 64'(out_valid), 64'd0);
      m_reset();
      rst_n = 1'b1;
      @(negedge clk);
      drive(1, mk(9, 7, 0, 0), 0, 0, 32'h0, 1); #1;
      chk("t6.no_stall", 64'(in_ready), 64'd1);
      cycle("t6_after");
      drive(0, 32'h0, 1, 7, 32'h77, 1); cycle("t6_latewb");

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r1, r2, rdv, wr;
         bit wide;
         wide = ($urandom % 8) == 0;
         rdv = wide ? int'($urandom % 32) : int'($urandom % 8);
         r1  = wide ? int'($urandom % 32) : int'($urandom % 8);
         r2  = int'($urandom % 8);
         wr  = int'($urandom % 8);
         if (($urandom % 2) == 1) begin
            for (int j = 1; j < 32; j++) if (m_pend[j]) begin wr = j; break; end
         end
         drive(($urandom % 4) != 0, mk(rdv, r1, r2, $urandom % 2), ($urandom % 3) == 0,
               wr, $urandom, ($urandom % 4) != 0);
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
